// File: rtl/pmem_pkg.sv
// Shared constants and loader state type for the program memory and its loader.
package pmem_pkg;

  localparam int unsigned PMEM_ADDR_W  = 8;
  localparam int unsigned PMEM_INSTR_W = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNT  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    WR   = 3'd4,
    CSUM = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } loader_state_t;

  // A load is in progress in every state except IDLE and ERR.
  function automatic logic loader_busy(input loader_state_t s);
    return (s != IDLE) && (s != ERR);
  endfunction

endpackage

// File: rtl/pmem_loader.sv
// Program memory load-port driver: assembles 12-bit instructions from a
// host byte stream (CNT, N x {HI,LO}, CSUM), writes them from address 0
// upward and validates the trailing checksum.
module pmem_loader
  import pmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = PMEM_ADDR_W,
  parameter int unsigned INSTR_W = PMEM_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               LE,
  output logic [ADDR_W-1:0]  LA,
  output logic [INSTR_W-1:0] LI,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic               w_in_ready;
  logic               w_accept;
  logic [7:0]         w_sum_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_remain;
  logic [7:0]         r_sum;
  logic [3:0]         r_nib;
  logic               r_le;
  logic [ADDR_W-1:0]  r_la;
  logic [INSTR_W-1:0] r_li;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  assign w_accept   = in_valid & w_in_ready;
  assign w_sum_next = r_sum + in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and in_ready (the only unregistered output).
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = CNT;
      end
      CNT: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = HI;
      end
      HI: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = (in_data[7:4] != 4'h0) ? ERR : LO;
      end
      LO: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = WR;
      end
      WR: begin
        w_next = (r_remain == '0) ? CSUM : HI;
      end
      CSUM: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = (w_sum_next == 8'h00) ? DONE : ERR;
      end
      DONE: begin
        w_next = IDLE;
      end
      ERR: begin
        if (start) w_next = CNT;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: address/count/checksum accumulation and registered outputs.
  // Status outputs are registered from w_next so they line up with the
  // state they describe (LE high for exactly the WR cycle, etc.).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_sum    <= '0;
      r_nib    <= '0;
      r_le     <= 1'b0;
      r_la     <= '0;
      r_li     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_le   <= (w_next == WR);
      r_busy <= loader_busy(w_next);
      r_done <= (w_next == DONE);
      r_err  <= (w_next == ERR);
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_sum    <= '0;
          end
        end
        CNT: begin
          if (w_accept) begin
            r_remain <= ADDR_W'(in_data);
            r_sum    <= w_sum_next;
          end
        end
        HI: begin
          if (w_accept) begin
            r_nib <= in_data[3:0];
            r_sum <= w_sum_next;
          end
        end
        LO: begin
          if (w_accept) begin
            r_li  <= INSTR_W'({r_nib, in_data});
            r_la  <= r_addr;
            r_sum <= w_sum_next;
          end
        end
        WR: begin
          // Address only advances when another pair follows, so a full
          // 256-entry image ends at 255 without wrapping.
          if (r_remain != '0) begin
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign LE       = r_le;
  assign LA       = r_la;
  assign LI       = r_li;
  assign busy     = r_busy;
  assign cpu_hold = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
